mult_job_sequencer: RTL
=======================

# mult_job_sequencer

Job sequencer placed directly upstream of the sequential multiplier. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. For each job it drives the multiplier's `start`/operand inputs, waits for `productDone`, and returns the product plus a per-job cycle count on a valid/ready result stream. Operands stay stable for the full multiplication, and no job is lost under back-pressure.

## Interface
- `WIDTH`, 2048, operand width; must match the multiplier's `WIDTH`.
- `DEPTH`, 2, operand FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO not full.
- `in_multiplier`  in  WIDTH  operand A.
- `in_multiplicand`  in  WIDTH  operand B.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_multiplier`  out  WIDTH  registered operand A to the multiplier.
- `mult_multiplicand`  out  WIDTH  registered operand B to the multiplier.
- `mult_product`  in  2*WIDTH  multiplier product.
- `mult_done`  in  1  multiplier `productDone`; treated as a level.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  result consumed.
- `out_product`  out  2*WIDTH  captured product.
- `out_cycles`  out  16  WAIT-cycle count of the job; saturates at 16'hFFFF.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.

## Operation
- **Push:** occurs on `in_valid & in_ready`. `in_ready = !full`; there is no push-through when full. Push and pop in the same cycle are legal at any occupancy below full.
- **Slot free:** defined as `!out_valid | out_ready`.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
- **IDLE:**
  - Condition: FIFO non-empty.
  - Action: pop the head into the `mult_*` operand registers.
  - Next state: ISSUE.
- **ISSUE:**
  - `mult_start`=1 for this cycle only.
  - Clear the counter to 0 and clear `armed`.
  - Next state: WAIT.
- **WAIT:**
  - The counter increments every cycle, saturating.
  - `armed` is set on any WAIT cycle with `mult_done`=0.
  - A qualified done is `mult_done & armed`. A stale level-high done from the previous job is therefore never accepted.
  - On a qualified done with the slot free: capture `mult_product` into `out_product` and the incremented count into `out_cycles`, set `out_valid`, and go to IDLE.
  - On a qualified done with the slot busy: freeze the counter (including this cycle) and go to HOLD.
- **HOLD:**
  - Wait for the slot to free.
  - Then capture `mult_product` and the frozen count, set `out_valid`, and go to IDLE.
  - `mult_product` is stable during HOLD because no new start is issued.
- **Result hand-off:**
  - `out_valid` clears on `out_ready` unless a new capture occurs in the same cycle; in that case it stays 1 with the new data.
  - Output data is stable while `out_valid & !out_ready`.
- **Operand hold:** `mult_multiplier`/`mult_multiplicand` change only on a pop, so they are constant from ISSUE through the end of WAIT/HOLD.
- **Reset (any time, including mid-WAIT):**
  - FIFO is emptied, FSM goes to IDLE, and `armed`=0.
  - Outputs: `mult_start`=0, `out_valid`=0, `busy`=0, and `in_ready`=1 once reset deasserts.
  - Operand, product and count registers are cleared to 0.
  - The in-flight job is discarded.

## Timing
- Push at the edge ending cycle 0 → IDLE pops at the end of cycle 1 → `mult_start`=1 in cycle 2 → WAIT from cycle 3.
- If the qualified done is in WAIT cycle k and the slot is free, `out_valid`=1 from cycle k+1.
- `out_cycles` = number of WAIT cycles up to and including the qualifying done cycle.
- Back-to-back jobs: minimum 2 cycles between a capture and the next `mult_start`.
- `mult_start` is never asserted in two consecutive cycles.

## Test plan
- **Single job.** Setup: WIDTH=8, model multiplier with done 4 cycles after start and done held high until the next start. Stimulus: push 13×11. Required response: `mult_start` pulses in cycle 2; `out_product`=143; `out_cycles`=4; `out_valid` rises 1 cycle after done.
- **FIFO full.** Stimulus: `out_ready`=0, push 3 pairs with DEPTH=2. Required response: `in_ready`=0 after 2 FIFO entries plus 1 in flight. First result 3×5=15 is held; job 2 sits in HOLD with counter frozen; raising `out_ready` drains 15, 7×9=63, 2×2=4 in order.
- **Stale done.** Stimulus: `mult_done` stays high through ISSUE and the first WAIT cycle of job 2. Required response: no capture until `mult_done` falls and rises again; product equals job 2's value.
- **Reset mid-WAIT.** Stimulus: assert `rst`=0 for 1 cycle during WAIT. Required response: `out_valid`=0, `busy`=0, `mult_start`=0 immediately (asynchronously); subsequent new job 6×6 returns 36.
- **Saturation.** Stimulus: model done delayed 70000 cycles. Required response: `out_cycles`=16'hFFFF and the product is still correct.
- **Max operands.** Stimulus: WIDTH=8, push 255×255. Required response: `out_product`=65025.

Source files
------------

// File: rtl/mult_job_sequencer.sv
// -----------------------------------------------------------------------------
// mult_job_sequencer
//
// Feeds a sequential multiplier with queued operand pairs and returns each
// product together with the number of cycles the job spent waiting on the
// multiplier.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous reset, active low
//   in_valid/in_ready operand-pair stream (in_ready = FIFO not full)
//   in_multiplier     operand A
//   in_multiplicand   operand B
//   mult_start        one-cycle start pulse to the multiplier
//   mult_multiplier   registered operand A, stable for the whole job
//   mult_multiplicand registered operand B, stable for the whole job
//   mult_product      multiplier product
//   mult_done         multiplier productDone (level)
//   out_valid/out_ready result stream
//   out_product       captured product
//   out_cycles        WAIT-cycle count of the job, saturating at 16'hFFFF
//   busy              FSM active or FIFO non-empty
// -----------------------------------------------------------------------------
module mult_job_sequencer #(
   parameter int WIDTH = 2048,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_multiplier,
   input  logic [WIDTH-1:0]   in_multiplicand,
   output logic               mult_start,
   output logic [WIDTH-1:0]   mult_multiplier,
   output logic [WIDTH-1:0]   mult_multiplicand,
   input  logic [2*WIDTH-1:0] mult_product,
   input  logic               mult_done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic [15:0]        out_cycles,
   output logic               busy
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_mem_a [DEPTH];
   logic [WIDTH-1:0]     r_mem_b [DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic                 r_armed;
   logic [15:0]          r_cnt;
   logic [WIDTH-1:0]     r_op_a;
   logic [WIDTH-1:0]     r_op_b;
   logic                 r_start;
   logic                 r_out_valid;
   logic [2*WIDTH-1:0]   r_out_product;
   logic [15:0]          r_out_cycles;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_push;
   logic                 w_slot_free;
   logic                 w_qdone;
   logic [15:0]          w_cnt_inc;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push      = in_valid && !w_full;
   assign w_slot_free = !r_out_valid || out_ready;
   // A done level left over from the previous job is ignored until the
   // multiplier has been seen low at least once in this job's WAIT phase.
   assign w_qdone     = mult_done && r_armed;
   assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

   assign in_ready          = !w_full;
   assign mult_start        = r_start;
   assign mult_multiplier   = r_op_a;
   assign mult_multiplicand = r_op_b;
   assign out_valid         = r_out_valid;
   assign out_product       = r_out_product;
   assign out_cycles        = r_out_cycles;
   assign busy              = (r_state != IDLE) || !w_empty;

   // FIFO storage carries no reset; only the pointers define its contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr[AW-1:0]] <= in_multiplier;
         r_mem_b[r_wr_ptr[AW-1:0]] <= in_multiplicand;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_armed       <= 1'b0;
         r_cnt         <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_start       <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_product <= '0;
         r_out_cycles  <= '0;
      end else begin
         r_start <= 1'b0;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         // A capture below overrides this clear in the same cycle.
         if (out_ready) r_out_valid <= 1'b0;

         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_op_a   <= r_mem_a[r_rd_ptr[AW-1:0]];
                  r_op_b   <= r_mem_b[r_rd_ptr[AW-1:0]];
                  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                  r_start  <= 1'b1;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_armed <= 1'b0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (!mult_done) r_armed <= 1'b1;
               if (w_qdone) begin
                  if (w_slot_free) begin
                     r_out_product <= mult_product;
                     r_out_cycles  <= w_cnt_inc;
                     r_out_valid   <= 1'b1;
                     r_state       <= IDLE;
                  end else begin
                     // Count includes the done cycle, then stays frozen in HOLD.
                     r_cnt   <= w_cnt_inc;
                     r_state <= HOLD;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            HOLD: begin
               if (w_slot_free) begin
                  r_out_product <= mult_product;
                  r_out_cycles  <= r_cnt;
                  r_out_valid   <= 1'b1;
                  r_state       <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
